// File: rtl/bus_pkg.sv
// Shared bus definitions: ID width, broadcast address, error-flag bit positions
// and the destination filter used by bus endpoints.
package bus_pkg;

  localparam int unsigned ID_W  = 8;
  localparam int unsigned ERR_W = 3;

  localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;

  typedef enum logic [1:0] {
    ERR_TX_UNDERFLOW = 2'd0,
    ERR_TX_OVERFLOW  = 2'd1,
    ERR_RX_OVERFLOW  = 2'd2
  } err_idx_e;

  function automatic logic id_match(input logic [ID_W-1:0] dest,
                                    input logic [ID_W-1:0] self,
                                    input logic [ID_W-1:0] bcast);
    return (dest == self) || (dest == bcast);
  endfunction

endpackage

// File: rtl/ep_fifo.sv
// Synchronous show-ahead FIFO: head is read combinationally from storage,
// overflow/underflow are single-cycle strobes for the attempted illegal access.
module ep_fifo #(
  parameter int unsigned width = 16,
  parameter int unsigned depth = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [width-1:0] wdata,
  input  logic             rd,
  output logic [width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned AW = $clog2(depth);
  localparam logic [AW:0] CNT_FULL = depth[AW:0];

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             rd_ok;
  logic             wr_ok;

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  // A read on a full FIFO frees the slot the same-edge write lands in.
  assign rd_ok     = rd && !empty;
  assign wr_ok     = wr && (!full || rd_ok);
  assign overflow  = wr && !wr_ok;
  assign underflow = rd && empty;

  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        rptr <= rptr + 1'b1;
      end
      if (wr_ok && !rd_ok) begin
        count <= count + 1'b1;
      end else if (!wr_ok && rd_ok) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_endpoint.sv
// Bus endpoint: a TX FIFO drained by the bus arbiter and an address-filtered
// RX FIFO drained by the user, with sticky error flags and a drop counter.
module bus_endpoint
  import bus_pkg::*;
#(
  parameter int unsigned      pckg_sz   = 16,
  parameter int unsigned      depth     = 8,
  parameter logic [ID_W-1:0]  id        = '0,
  parameter logic [ID_W-1:0]  broadcast = BCAST_ID
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pndng,
  input  logic               pop,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               tx_wr,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  input  logic               rx_rd,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  output logic [ERR_W-1:0]   err,
  output logic [7:0]         drop_cnt
);

  logic [ID_W-1:0] dest;
  logic            addr_hit;
  logic            rx_accept;
  logic            rx_filtered;
  logic            tx_empty;
  logic            tx_ovf;
  logic            tx_udf;
  logic            rx_empty;
  logic            rx_ovf;
  logic            unused_rx_full;
  logic            unused_rx_udf;

  assign dest        = D_push[pckg_sz-1 -: ID_W];
  assign addr_hit    = id_match(dest, id, broadcast);
  assign rx_accept   = push && addr_hit;
  assign rx_filtered = push && !addr_hit;

  assign pndng    = !tx_empty;
  assign rx_valid = !rx_empty;

  ep_fifo #(
    .width (pckg_sz),
    .depth (depth)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr        (tx_wr),
    .wdata     (tx_data),
    .rd        (pop),
    .rdata     (D_pop),
    .full      (tx_full),
    .empty     (tx_empty),
    .overflow  (tx_ovf),
    .underflow (tx_udf)
  );

  // rx_rd on an empty RX FIFO is simply ignored, so its underflow strobe is unused.
  ep_fifo #(
    .width (pckg_sz),
    .depth (depth)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr        (rx_accept),
    .wdata     (D_push),
    .rd        (rx_rd),
    .rdata     (rx_data),
    .full      (unused_rx_full),
    .empty     (rx_empty),
    .overflow  (rx_ovf),
    .underflow (unused_rx_udf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      err <= '0;
    end else begin
      if (tx_udf) begin
        err[ERR_TX_UNDERFLOW] <= 1'b1;
      end
      if (tx_ovf) begin
        err[ERR_TX_OVERFLOW] <= 1'b1;
      end
      if (rx_ovf) begin
        err[ERR_RX_OVERFLOW] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (rx_filtered && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_endpoint.sv
// Directed bench for bus_endpoint (id=2, depth=8); expected packets are queued
// at issue time and popped by a negedge monitor when the DUT dequeues.
module tb_bus_endpoint;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          pndng;
  logic          pop;
  logic [W-1:0]  D_pop;
  logic          push;
  logic [W-1:0]  D_push;
  logic          tx_wr;
  logic [W-1:0]  tx_data;
  logic          tx_full;
  logic          rx_rd;
  logic          rx_valid;
  logic [W-1:0]  rx_data;
  logic [2:0]    err;
  logic [7:0]    drop_cnt;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] txq[$];
  logic [W-1:0] rxq[$];

  always #5 clk = ~clk;

  bus_endpoint #(
    .pckg_sz   (W),
    .depth     (DEPTH),
    .id        (8'h02),
    .broadcast (8'hFF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .pop      (pop),
    .D_pop    (D_pop),
    .push     (push),
    .D_push   (D_push),
    .tx_wr    (tx_wr),
    .tx_data  (tx_data),
    .tx_full  (tx_full),
    .rx_rd    (rx_rd),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .err      (err),
    .drop_cnt (drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: inputs are stable at negedge, so a dequeue seen here happens at the next posedge.
  always @(negedge clk) begin
    if (reset) begin
      txq.delete();
      rxq.delete();
    end else begin
      if (pop && pndng) begin
        if (txq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL D_pop_unexpected actual=%h required=none", D_pop);
        end else begin
          chk("D_pop", D_pop, txq.pop_front());
        end
      end
      if (rx_rd && rx_valid) begin
        if (rxq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_data_unexpected actual=%h required=none", rx_data);
        end else begin
          chk("rx_data", rx_data, rxq.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pop   = 1'b0;
    push  = 1'b0;
    tx_wr = 1'b0;
    rx_rd = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wr_tx(input logic [W-1:0] d, input bit accept);
    tx_wr   = 1'b1;
    tx_data = d;
    if (accept) txq.push_back(d);
    tick();
    tx_wr = 1'b0;
  endtask

  task automatic push_rx(input logic [W-1:0] d, input bit accept);
    push   = 1'b1;
    D_push = d;
    if (accept) rxq.push_back(d);
    tick();
    push = 1'b0;
  endtask

  task automatic pop_n(input int n);
    pop = 1'b1;
    repeat (n) tick();
    pop = 1'b0;
  endtask

  task automatic rd_n(input int n);
    rx_rd = 1'b1;
    repeat (n) tick();
    rx_rd = 1'b0;
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    tx_data = '0;
    D_push  = '0;
    reset   = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_pndng", pndng, 0);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_drop_cnt", drop_cnt, 0);

    // Three TX packets out in order; pndng falls only after the third pop
    wr_tx(16'h0111, 1);
    chk("pndng_first_wr", pndng, 1);
    wr_tx(16'h0222, 1);
    wr_tx(16'h0333, 1);
    pop_n(2);
    chk("pndng_two_popped", pndng, 1);
    pop_n(1);
    chk("pndng_all_popped", pndng, 0);
    chk("err_after_tx", err, 0);

    // RX filter: own ID and broadcast kept, foreign ID dropped
    push_rx(16'h02AB, 1);
    chk("rx_valid_first", rx_valid, 1);
    push_rx(16'hFFCD, 1);
    push_rx(16'h05EE, 0);
    chk("drop_cnt_one", drop_cnt, 1);
    rd_n(2);
    chk("rx_valid_drained", rx_valid, 0);
    rd_n(1);
    chk("rx_rd_empty_ignored", rx_valid, 0);
    chk("err_after_rx", err, 0);

    // Fill TX, write+pop while full, then overflow
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wr_tx(16'h0A00 + 16'(i), 1);
      if (i == DEPTH - 2) chk("tx_full_seven", tx_full, 0);
    end
    chk("tx_full_eight", tx_full, 1);
    tx_wr   = 1'b1;
    tx_data = 16'h0AFF;
    pop     = 1'b1;
    txq.push_back(16'h0AFF);
    tick();
    idle();
    chk("tx_full_wr_pop", tx_full, 1);
    chk("err_wr_pop_full", err, 3'b000);
    wr_tx(16'h0BAD, 0);
    chk("err_tx_ovf", err, 3'b010);
    chk("tx_full_after_ovf", tx_full, 1);
    pop_n(DEPTH);
    chk("pndng_tx_drained", pndng, 0);
    chk("tx_full_drained", tx_full, 0);

    // Underflow, then reset clears the sticky flags
    do_reset();
    chk("err_cleared", err, 0);
    chk("drop_cnt_cleared", drop_cnt, 0);
    pop = 1'b1;
    tick();
    idle();
    chk("err_tx_udf", err, 3'b001);
    chk("pndng_after_udf", pndng, 0);
    tx_wr   = 1'b1;
    tx_data = 16'h0C0C;
    pop     = 1'b1;
    txq.push_back(16'h0C0C);
    tick();
    idle();
    chk("pndng_wr_pop_empty", pndng, 1);
    chk("err_wr_pop_empty", err, 3'b001);
    pop_n(1);
    chk("pndng_after_c0c", pndng, 0);
    do_reset();
    chk("err_reset_udf", err, 0);

    // RX overflow and push+rx_rd while full
    for (int unsigned i = 0; i < DEPTH; i++) push_rx(16'h0200 + 16'(i), 1);
    chk("rx_valid_full", rx_valid, 1);
    push   = 1'b1;
    D_push = 16'h02F0;
    rx_rd  = 1'b1;
    rxq.push_back(16'h02F0);
    tick();
    idle();
    chk("err_push_rd_full", err, 0);
    push_rx(16'h02F1, 0);
    chk("err_rx_ovf", err, 3'b100);
    rd_n(DEPTH);
    chk("rx_valid_rx_drained", rx_valid, 0);

    // Reset mid-operation discards queued data and same-cycle strobes
    do_reset();
    wr_tx(16'h0D01, 1);
    wr_tx(16'h0D02, 1);
    push_rx(16'h0203, 1);
    reset   = 1'b1;
    tx_wr   = 1'b1;
    tx_data = 16'h0D03;
    pop     = 1'b1;
    push    = 1'b1;
    D_push  = 16'h0204;
    rx_rd   = 1'b1;
    tick();
    idle();
    reset = 1'b0;
    chk("midrst_pndng", pndng, 0);
    chk("midrst_rx_valid", rx_valid, 0);
    chk("midrst_tx_full", tx_full, 0);
    chk("midrst_err", err, 0);
    wr_tx(16'h0E01, 1);
    pop_n(1);
    chk("pndng_post_midrst", pndng, 0);

    // Drop counter saturation
    push   = 1'b1;
    D_push = 16'h3355;
    repeat (254) tick();
    chk("drop_cnt_254", drop_cnt, 254);
    repeat (46) tick();
    push = 1'b0;
    chk("drop_cnt_sat", drop_cnt, 255);
    chk("rx_valid_after_drops", rx_valid, 0);

    tick();
    chk("txq_drained", txq.size(), 0);
    chk("rxq_drained", rxq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
